// File: rtl/gf16_mix_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf16_mix_sequencer : serial GF(2^4) circulant column mixer, one MAC per cycle
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module gf16_mix_sequencer #(
  parameter int ROUNDS = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] D_IN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [15:0] D_OUT,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        BUSY
);

  localparam logic [3:0] C_LAST_ROUND = 4'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_live;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [15:0] r_dout;
  logic [3:0]  r_acc;
  logic [1:0]  r_i;
  logic [1:0]  r_j;
  logic [3:0]  r_round;

  logic        w_accept;
  logic [3:0]  w_xj;
  logic [1:0]  w_csel;
  logic [3:0]  w_prod;
  logic [3:0]  w_acc_next;
  logic [15:0] w_y_new;
  logic        w_last_cell;
  logic        w_last_round;

  function automatic logic [3:0] mul2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  assign w_xj         = r_x[{r_j, 2'b00} +: 4];
  assign w_csel       = r_j - r_i;
  assign w_last_cell  = (r_i == 2'd3) && (r_j == 2'd3);
  assign w_last_round = (r_round == C_LAST_ROUND);

  // Coefficient ring C = {2,5,1,4} indexed by (j - i) mod 4
  always_comb begin
    w_prod = w_xj;
    case (w_csel)
      2'd0:    w_prod = mul2(w_xj);
      2'd1:    w_prod = mul2(mul2(w_xj)) ^ w_xj;
      2'd2:    w_prod = w_xj;
      default: w_prod = mul2(mul2(w_xj));
    endcase
  end

  assign w_acc_next = r_acc ^ w_prod;

  always_comb begin
    w_y_new = r_y;
    w_y_new[{r_i, 2'b00} +: 4] = w_acc_next;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b0;
    case (r_state)
      IDLE: begin
        IN_READY = r_live;
        if (IN_VALID && r_live) begin
          w_accept = 1'b1;
          w_next   = MAC;
        end
      end
      MAC: begin
        BUSY = 1'b1;
        if (w_last_cell && w_last_round) w_next = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // r_live keeps IN_READY low while reset is held and for its release edge
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_live  <= 1'b0;
      r_x     <= 16'h0000;
      r_y     <= 16'h0000;
      r_dout  <= 16'h0000;
      r_acc   <= 4'h0;
      r_i     <= 2'd0;
      r_j     <= 2'd0;
      r_round <= 4'h0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_x     <= D_IN;
        r_acc   <= 4'h0;
        r_i     <= 2'd0;
        r_j     <= 2'd0;
        r_round <= 4'h0;
      end else if (r_state == MAC) begin
        if (r_j == 2'd3) begin
          r_y   <= w_y_new;
          r_acc <= 4'h0;
          r_i   <= r_i + 2'd1;
          r_j   <= 2'd0;
          if (r_i == 2'd3) begin
            if (w_last_round) begin
              r_dout <= w_y_new;
            end else begin
              r_x     <= w_y_new;
              r_round <= r_round + 4'h1;
            end
          end
        end else begin
          r_acc <= w_acc_next;
          r_j   <= r_j + 2'd1;
        end
      end
    end
  end

  assign D_OUT = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_gf16_mix_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gf16_mix_sequencer : directed + random bench for ROUNDS=1 and ROUNDS=3
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_gf16_mix_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d_in = 16'h0000;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;

  logic        ir1, ov1, bz1, ir3, ov3, bz3;
  logic [15:0] do1, do3;
  logic        ir, ov, bz;
  logic [15:0] dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf16_mix_sequencer #(.ROUNDS(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .D_IN(d_in), .IN_VALID(in_valid && !sel),
    .IN_READY(ir1), .D_OUT(do1), .OUT_VALID(ov1), .OUT_READY(out_ready && !sel),
    .BUSY(bz1)
  );

  gf16_mix_sequencer #(.ROUNDS(3)) dut3 (
    .CLK(clk), .RST_N(rst_n), .D_IN(d_in), .IN_VALID(in_valid && sel),
    .IN_READY(ir3), .D_OUT(do3), .OUT_VALID(ov3), .OUT_READY(out_ready && sel),
    .BUSY(bz3)
  );

  assign ir   = sel ? ir3 : ir1;
  assign ov   = sel ? ov3 : ov1;
  assign bz   = sel ? bz3 : bz1;
  assign dout = sel ? do3 : do1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    logic [4:0] tt;
    p = 4'h0;
    t = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) p = p ^ t;
      tt = {t, 1'b0};
      if (tt[4]) tt = tt ^ 5'h13;
      t = tt[3:0];
    end
    return p;
  endfunction

  function automatic logic [15:0] mix(input logic [15:0] w, input int rounds);
    logic [3:0]  cf [4];
    logic [15:0] x;
    logic [15:0] y;
    cf[0] = 4'h2; cf[1] = 4'h5; cf[2] = 4'h1; cf[3] = 4'h4;
    x = w;
    for (int r = 0; r < rounds; r++) begin
      y = 16'h0000;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          y[4*i +: 4] = y[4*i +: 4] ^ gf_mul(cf[(j - i) & 3], x[4*j +: 4]);
      x = y;
    end
    return x;
  endfunction

  // Accept w, measure latency/BUSY, hold DONE for 'stall' cycles while offering a decoy word
  task automatic run_word(input logic [15:0] w, input logic [15:0] exp,
                          input int lat_exp, input int stall);
    int n;
    int busyc;
    check("accept_ready", 16'(ir), 16'h1);
    d_in = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    busyc = 0;
    while (!ov && n < lat_exp + 20) begin
      if (bz) busyc++;
      tick();
      n++;
    end
    check("latency", 16'(n), 16'(lat_exp));
    check("busy_cycles", 16'(busyc), 16'(lat_exp));
    check("result", dout, exp);
    check("busy_in_done", 16'(bz), 16'h0);
    for (int s = 0; s < stall; s++) begin
      d_in = ~w;
      in_valid = 1'b1;
      tick();
      check("stall_dout", dout, exp);
      check("stall_in_ready", 16'(ir), 16'h0);
      check("stall_out_valid", 16'(ov), 16'h1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_out_valid", 16'(ov), 16'h0);
    check("post_hs_in_ready", 16'(ir), 16'h1);
    check("post_hs_dout", dout, exp);
  endtask

  initial begin
    logic [15:0] w;

    // Reset held 3 cycles while IN_VALID is asserted
    rst_n = 1'b0;
    d_in = 16'h1234;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_in_ready", 16'(ir1), 16'h0);
      check("rst_out_valid", 16'(ov1), 16'h0);
      check("rst_dout", do1, 16'h0000);
      check("rst_busy", 16'(bz1), 16'h0);
      check("rst_in_ready3", 16'(ir3), 16'h0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("release_in_ready", 16'(ir1), 16'h1);
    check("release_busy", 16'(bz1), 16'h0);

    // Directed ROUNDS=1 vectors
    sel = 1'b0;
    run_word(16'h0001, 16'h5142, 16, 0);
    run_word(16'h000F, 16'h6F9D, 16, 0);
    run_word(16'h0000, 16'h0000, 16, 0);
    run_word(16'h0010, 16'h1425, 16, 0);

    // Backpressure with a decoy word offered for 10 cycles
    run_word(16'h0001, 16'h5142, 16, 10);
    check("decoy_not_captured_busy", 16'(bz1), 16'h0);

    // Reset asserted so that MAC edge 7 samples it
    d_in = 16'h1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("mid_busy_before_rst", 16'(bz1), 16'h1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_in_ready", 16'(ir1), 16'h0);
    check("mid_rst_out_valid", 16'(ov1), 16'h0);
    check("mid_rst_busy", 16'(bz1), 16'h0);
    check("mid_rst_dout", do1, 16'h0000);
    rst_n = 1'b1;
    tick();
    check("mid_release_in_ready", 16'(ir1), 16'h1);
    run_word(16'h000F, 16'h6F9D, 16, 0);
    run_word(16'hA5C3, mix(16'hA5C3, 1), 16, 1);

    // ROUNDS=3 random words with random downstream stalls
    sel = 1'b1;
    tick();
    for (int n = 0; n < 200; n++) begin
      w = 16'($urandom);
      run_word(w, mix(w, 3), 48, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gf16_mix_sequencer.md
# gf16_mix_sequencer

Sequential GF(2^4) column-mixing engine for the TRNG post-processing chain. It accepts one 16-bit word of four nibbles, multiplies it by a fixed 4x4 circulant matrix over GF(2^4) using a single shared constant-multiplier/accumulator, and returns the mixed word. Full passes repeat ROUNDS times. The block sits between the raw-bit packer and the output FIFO, with valid/ready handshakes on both sides.

## Interface
- ROUNDS, 1: number of mixing passes applied per accepted word. Legal range is 1..15.
- CLK  input  1  single clock. All logic is rising-edge.
- RST_N  input  1  synchronous, active-low reset.
- D_IN  input  16  input word. Nibble x_j = D_IN[4j+3:4j], j=0..3.
- IN_VALID  input  1  D_IN is valid.
- IN_READY  output  1  block can accept a word. High only in IDLE.
- D_OUT  output  16  mixed word. Nibble y_i = D_OUT[4i+3:4i]. Registered.
- OUT_VALID  output  1  D_OUT holds a finished result.
- OUT_READY  input  1  downstream accepts D_OUT.
- BUSY  output  1  high in MAC state.

## Operation
- Field arithmetic:
  - GF(2^4) with reduction polynomial x^4+x+1.
  - Addition is XOR.
  - mul2(a) = {a[2:0],0} ^ (a[3] ? 4'h3 : 0).
  - mul4 = mul2(mul2).
  - mul5 = mul4 ^ a.
  - mul1 = a.
- Matrix:
  - M[i][j] = C[(j-i) mod 4], with C = {2,5,1,4}.
  - Example row: y0 = 2x0 ^ 5x1 ^ x2 ^ 4x3.
- Datapath:
  - One shared multiplier. A coefficient select picks one of {1,2,4,5}.
  - One 4-bit accumulator, a 16-bit working register X and a 16-bit result register Y.
- FSM states: IDLE, MAC, DONE.
  - IDLE: IN_READY=1. On IN_VALID&&IN_READY, X<=D_IN, cell counter {i,j}<=0, round counter<=0, accumulator<=0, then go to MAC.
  - MAC: each cycle, acc_next = acc ^ mul(C[(j-i)&3], x_j).
    - When j==3, write y_i<=acc_next, clear acc and advance i. Otherwise advance j.
    - After cell (3,3): if round==ROUNDS-1, go to DONE. Otherwise X<=Y (using the just-written y3), round++, cell counter<=0, stay in MAC.
  - DONE: OUT_VALID=1 and D_OUT=Y, both held stable. On OUT_READY, go to IDLE.
- IN_VALID outside IDLE is ignored. Nothing is captured or queued.
- OUT_READY outside DONE is ignored.
- Counters wrap naturally: j 3->0 with i++, and i 3->0 at round end. No other wrap exists.
- Reset: RST_N low at any edge, including mid-MAC or in DONE, forces IDLE and discards work in progress.

## Timing
- Reset values: IN_READY=0 while RST_N is low and 1 in the first cycle after release. OUT_VALID=0, BUSY=0, D_OUT=16'h0000. Internal X, Y, acc and counters are all 0.
- Acceptance edge is E0. MAC processes one cell per edge on E1..E(16*ROUNDS).
- OUT_VALID rises in the cycle after edge E(16*ROUNDS), so latency from acceptance is 16*ROUNDS cycles.
- Output handshake completes on the edge where OUT_VALID&&OUT_READY. On the next cycle OUT_VALID=0 and IN_READY=1.
- There is no same-cycle IN_READY bypass. Minimum period is 16*ROUNDS+2 cycles per word.
- BUSY is high exactly 16*ROUNDS cycles per word.
- D_OUT changes only on the MAC-to-DONE transition or on reset.

## Test plan
- Reset: hold RST_N low 3 cycles with IN_VALID=1 -> IN_READY=0, OUT_VALID=0, D_OUT=16'h0000. Release -> IN_READY=1 next cycle.
- Unit vector (ROUNDS=1): D_IN=16'h0001 -> D_OUT=16'h5142, with OUT_VALID high exactly 16 cycles after acceptance.
- Reduction check (ROUNDS=1): D_IN=16'h000F -> D_OUT=16'h6F9D. Also D_IN=16'h0000 -> 16'h0000.
- Backpressure and ignore: hold OUT_READY=0 for 10 cycles in DONE while driving IN_VALID with a new word -> D_OUT stable, IN_READY=0, new word not captured. Raise OUT_READY -> IN_READY=1 on the following cycle.
- Reset mid-operation: assert RST_N low at MAC cycle 7 -> next cycle IDLE, all outputs at reset values. A fresh word then produces the correct result.
- ROUNDS=3, 200 random words with random OUT_READY stalls -> each D_OUT equals a model applying the matrix 3 times, latency is 48 cycles, and BUSY is high for 48 cycles per word.
